// File: rtl/mac_sequencer_if.sv
// Operand, multiplier and batch-result signals of the MAC sequencer.
// slave is the sequencer side; master is the surrounding environment.
interface mac_sequencer_if #(
    parameter int ACC_W = 10
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_a;
    logic [3:0]       in_b;
    logic [3:0]       mult_a;
    logic [3:0]       mult_b;
    logic [7:0]       mult_product;
    logic             acc_valid;
    logic             acc_ready;
    logic [ACC_W-1:0] acc_sum;
    logic             overflow;

    modport slave (
        input  in_valid, in_a, in_b, mult_product, acc_ready,
        output in_ready, mult_a, mult_b, acc_valid, acc_sum, overflow
    );

    modport master (
        output in_valid, in_a, in_b, mult_product, acc_ready,
        input  in_ready, mult_a, mult_b, acc_valid, acc_sum, overflow
    );
endinterface

// File: rtl/mac_sequencer.sv
// Feeds registered operand pairs to an external 4x4 multiplier and
// sums N_OPS products per batch, handing the total out on a handshake.
module mac_sequencer #(
    parameter int N_OPS = 4,
    parameter int ACC_W = 10
) (
    input logic            clk,
    input logic            rst_n,
    mac_sequencer_if.slave bus
);
    localparam int CNT_W = (N_OPS > 1) ? $clog2(N_OPS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_OPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic [3:0]       a_q;
    logic [3:0]       b_q;
    logic [ACC_W:0]   sum;
    logic             take;
    logic             drain;
    logic             ready;
    logic             valid;
    logic             last;

    // One spare bit on top of the accumulator catches the carry-out.
    assign sum  = {1'b0, acc} + {{(ACC_W-7){1'b0}}, bus.mult_product};
    assign last = (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        drain     = 1'b0;
        ready     = 1'b0;
        valid     = 1'b0;
        unique case (state)
            IDLE: begin
                ready = rst_n;
                if (bus.in_valid) begin
                    take      = 1'b1;
                    state_nxt = EVAL;
                end
            end
            EVAL: begin
                state_nxt = last ? DONE : IDLE;
            end
            DONE: begin
                valid = 1'b1;
                if (bus.acc_ready) begin
                    drain     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
            ovf   <= 1'b0;
            count <= '0;
        end else begin
            if (take) begin
                a_q <= bus.in_a;
                b_q <= bus.in_b;
            end
            if (state == EVAL) begin
                acc <= sum[ACC_W-1:0];
                if (sum[ACC_W]) begin
                    ovf <= 1'b1;
                end
                count <= last ? '0 : count + CNT_W'(1);
            end
            if (drain) begin
                acc <= '0;
                ovf <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.acc_valid = valid;
    assign bus.mult_a    = a_q;
    assign bus.mult_b    = b_q;
    assign bus.acc_sum   = acc;
    assign bus.overflow  = ovf;
endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench for mac_sequencer: two instances (10-bit/4-op and
// 8-bit/2-op), batch totals predicted from plain sums of products.
module tb_mac_sequencer;
    localparam int W0 = 10;
    localparam int N0 = 4;
    localparam int W1 = 8;
    localparam int N1 = 2;

    typedef struct {
        int sum;
        bit ovf;
        int idx;
        bit lat;
    } exp_t;

    logic clk;
    logic rst_n;
    bit   rnd_rdy;
    int   vec;
    int   err;

    exp_t q0[$];
    exp_t q1[$];
    time  fa0[$];
    time  hs0[$];
    logic [3:0] pa[N0];
    logic [3:0] pb[N0];
    logic [3:0] pa1[N1];
    logic [3:0] pb1[N1];

    mac_sequencer_if #(.ACC_W(W0)) b0 ();
    mac_sequencer_if #(.ACC_W(W1)) b1 ();

    mac_sequencer #(.N_OPS(N0), .ACC_W(W0)) dut0 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (b0)
    );

    mac_sequencer #(.N_OPS(N1), .ACC_W(W1)) dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (b1)
    );

    // Stand-ins for the external combinational multiplier.
    assign b0.mult_product = {4'b0, b0.mult_a} * {4'b0, b0.mult_b};
    assign b1.mult_product = {4'b0, b1.mult_a} * {4'b0, b1.mult_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] ex);
        vec++;
        if (act !== ex) begin
            err++;
            $display("FAIL %s: got %0d want %0d", nm, act, ex);
        end
    endtask

    always @(posedge clk) begin
        if (rnd_rdy) begin
            #1 b0.acc_ready = 1'($urandom_range(0, 1));
        end
    end

    always @(negedge clk) begin : mon0
        exp_t e;
        if (rst_n && b0.acc_valid) begin
            chk("done_in_ready0", b0.in_ready, 0);
            if (q0.size() == 0) begin
                vec++;
                err++;
                $display("FAIL unexpected_acc0: got %0d want none", b0.acc_sum);
            end else begin
                e = q0[0];
                chk("acc_sum0", b0.acc_sum, e.sum);
                chk("overflow0", b0.overflow, e.ovf);
                if (b0.acc_ready) begin
                    void'(q0.pop_front());
                    @(posedge clk);
                    hs0.push_back($time);
                    if (e.lat) chk("latency0", 32'($time - fa0[e.idx]), 80);
                    #1;
                    chk("valid_one_cycle0", b0.acc_valid, 0);
                end
            end
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (rst_n && b1.acc_valid) begin
            chk("done_in_ready1", b1.in_ready, 0);
            if (q1.size() == 0) begin
                vec++;
                err++;
                $display("FAIL unexpected_acc1: got %0d want none", b1.acc_sum);
            end else begin
                e = q1[0];
                chk("acc_sum1", b1.acc_sum, e.sum);
                chk("overflow1", b1.overflow, e.ovf);
                if (b1.acc_ready) begin
                    void'(q1.pop_front());
                    @(posedge clk);
                    #1;
                    chk("clear_ovf1", b1.overflow, 0);
                    chk("clear_sum1", b1.acc_sum, 0);
                end
            end
        end
    end

    task automatic send0(input logic [3:0] a, input logic [3:0] b,
                         input int bub, output time t);
        bit ok;
        t = 0;
        repeat (bub) begin
            @(posedge clk);
            #1;
        end
        b0.in_valid = 1'b1;
        b0.in_a     = a;
        b0.in_b     = b;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = b0.in_ready;
        end
        if (!ok) begin
            vec++;
            err++;
            $display("FAIL accept_timeout0: got in_ready 0 want 1");
        end else begin
            @(posedge clk);
            t = $time;
            #1;
            chk("mult_a0", b0.mult_a, a);
            chk("mult_b0", b0.mult_b, b);
        end
        b0.in_valid = 1'b0;
    endtask

    task automatic send1(input logic [3:0] a, input logic [3:0] b,
                         input int bub);
        bit ok;
        repeat (bub) begin
            @(posedge clk);
            #1;
        end
        b1.in_valid = 1'b1;
        b1.in_a     = a;
        b1.in_b     = b;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = b1.in_ready;
        end
        if (!ok) begin
            vec++;
            err++;
            $display("FAIL accept_timeout1: got in_ready 0 want 1");
        end else begin
            @(posedge clk);
            #1;
            chk("mult_a1", b1.mult_a, a);
            chk("mult_b1", b1.mult_b, b);
        end
        b1.in_valid = 1'b0;
    endtask

    task automatic batch0(input int maxbub, input bit lat);
        exp_t e;
        int   tot;
        time  t;
        logic [3:0] la[N0];
        logic [3:0] lb[N0];
        tot = 0;
        for (int i = 0; i < N0; i++) begin
            la[i] = pa[i];
            lb[i] = pb[i];
            tot  += int'(pa[i]) * int'(pb[i]);
        end
        e.sum = tot % (1 << W0);
        e.ovf = (tot >= (1 << W0));
        e.idx = fa0.size();
        e.lat = lat;
        q0.push_back(e);
        for (int i = 0; i < N0; i++) begin
            send0(la[i], lb[i], $urandom_range(0, maxbub), t);
            if (i == 0) fa0.push_back(t);
        end
    endtask

    task automatic batch1(input int maxbub);
        exp_t e;
        int   tot;
        tot = 0;
        for (int i = 0; i < N1; i++) tot += int'(pa1[i]) * int'(pb1[i]);
        e.sum = tot % (1 << W1);
        e.ovf = (tot >= (1 << W1));
        e.idx = 0;
        e.lat = 1'b0;
        q1.push_back(e);
        for (int i = 0; i < N1; i++) send1(pa1[i], pb1[i], $urandom_range(0, maxbub));
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 300 && (q0.size() != 0 || q1.size() != 0); i++)
            @(negedge clk);
        chk(nm, q0.size() + q1.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int bp_idx;
        int nx_idx;
        vec = 0;
        err = 0;
        rnd_rdy = 1'b0;
        rst_n = 1'b0;
        b0.in_valid = 1'b0; b0.in_a = '0; b0.in_b = '0; b0.acc_ready = 1'b1;
        b1.in_valid = 1'b0; b1.in_a = '0; b1.in_b = '0; b1.acc_ready = 1'b1;
        #22;
        chk("rst_in_ready0", b0.in_ready, 0);
        chk("rst_acc_valid0", b0.acc_valid, 0);
        chk("rst_acc_sum0", b0.acc_sum, 0);
        chk("rst_overflow0", b0.overflow, 0);
        chk("rst_mult_a0", b0.mult_a, 0);
        chk("rst_in_ready1", b1.in_ready, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready0", b0.in_ready, 1);
        chk("post_rst_ready1", b1.in_ready, 1);
        @(posedge clk);
        #1;

        // 8-bit, 2-op instance: wraparound and overflow clear.
        pa1 = '{15, 15}; pb1 = '{15, 15};
        batch1(0);
        pa1 = '{1, 3}; pb1 = '{2, 4};
        batch1(0);
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < N1; i++) begin
                pa1[i] = 4'($urandom_range(0, 15));
                pb1[i] = 4'($urandom_range(0, 15));
            end
            batch1(2);
        end
        drain("drain1");

        // Reference batch, no bubbles, latency checked.
        pa = '{3, 15, 0, 7}; pb = '{5, 15, 9, 2};
        batch0(0, 1'b1);
        drain("drain_t1");

        // Backpressure while the next batch's first pair waits.
        bp_idx = fa0.size();
        fork
            begin
                pa = '{15, 15, 15, 15}; pb = '{15, 15, 15, 15};
                batch0(0, 1'b0);
                pa = '{1, 1, 1, 1}; pb = '{1, 1, 1, 1};
                batch0(0, 1'b0);
            end
            begin
                bit seen;
                b0.acc_ready = 1'b0;
                seen = 1'b0;
                for (int i = 0; i < 200 && !seen; i++) begin
                    @(negedge clk);
                    seen = b0.acc_valid;
                end
                chk("bp_seen", seen, 1);
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_valid_hold", b0.acc_valid, 1);
                end
                @(posedge clk);
                #1 b0.acc_ready = 1'b1;
            end
        join
        drain("drain_t3");
        nx_idx = bp_idx + 1;
        chk("bp_pair_held", fa0[nx_idx] > hs0[bp_idx], 1);

        // Reference batch with random in_valid bubbles.
        for (int k = 0; k < 3; k++) begin
            pa = '{3, 15, 0, 7}; pb = '{5, 15, 9, 2};
            batch0(3, 1'b0);
        end
        drain("drain_t5");
        chk("hold_mult_a", b0.mult_a, 7);
        chk("hold_mult_b", b0.mult_b, 2);

        // Random operands, bubbles and output backpressure.
        rnd_rdy = 1'b1;
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < N0; i++) begin
                pa[i] = 4'($urandom_range(0, 15));
                pb[i] = 4'($urandom_range(0, 15));
            end
            batch0(3, 1'b0);
        end
        rnd_rdy = 1'b0;
        @(posedge clk);
        #2 b0.acc_ready = 1'b1;
        drain("drain_rand");

        // Reset mid-batch discards the partial sum.
        begin
            time t;
            send0(4, 4, 0, t);
            send0(5, 5, 0, t);
            @(posedge clk);
            #3 rst_n = 1'b0;
            #1;
            chk("mid_rst_ready", b0.in_ready, 0);
            chk("mid_rst_valid", b0.acc_valid, 0);
            chk("mid_rst_sum", b0.acc_sum, 0);
            chk("mid_rst_ovf", b0.overflow, 0);
            chk("mid_rst_mult_a", b0.mult_a, 0);
            chk("mid_rst_mult_b", b0.mult_b, 0);
            @(negedge clk);
            #2 rst_n = 1'b1;
            @(posedge clk);
            #1;
        end
        pa = '{2, 2, 2, 2}; pb = '{3, 3, 3, 3};
        batch0(0, 1'b0);
        drain("drain_t6");

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule

// File: doc/mac_sequencer.md
Name: mac_sequencer

Overview:
- Multiply-accumulate sequencer built around the existing 4x4 combinational multiplier (a, b -> 8-bit product).
- Upstream side: accepts 4-bit operand pairs over a valid/ready handshake, registers them, and drives the multiplier's a/b inputs.
- Downstream side: consumes the 8-bit product, sums N_OPS products into an accumulator, and presents the total over a valid/ready output handshake.
- The multiplier is instantiated outside this block; only its a, b and product signals connect here.

Parameters:
- N_OPS, 4: products summed per batch; must be >= 1.
- ACC_W, 10: accumulator width in bits; must be >= 8.

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair on in_a/in_b is valid.
- in_ready  output  1  block can accept an operand pair.
- in_a  input  4  multiplicand.
- in_b  input  4  multiplier.
- mult_a  output  4  registered operand to multiplier port a.
- mult_b  output  4  registered operand to multiplier port b.
- mult_product  input  8  product returned by the multiplier (combinational from mult_a/mult_b).
- acc_valid  output  1  acc_sum holds a completed batch total.
- acc_ready  input  1  downstream accepts acc_sum.
- acc_sum  output  ACC_W  batch total.
- overflow  output  1  sticky: batch sum exceeded 2^ACC_W - 1.

Behaviour:
Reset (rst_n low, asynchronous, any state):
- State goes to IDLE.
- mult_a, mult_b, accumulator, op counter, acc_valid and overflow all go to 0.
- in_ready is 0 while rst_n is low; it is 1 from the first cycle after release.

States:
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready at an edge: mult_a <= in_a, mult_b <= in_b, go to EVAL.
  - Otherwise hold; bubbles on in_valid have no effect.
- EVAL:
  - in_ready = 0.
  - At the edge: acc <= acc + mult_product (zero-extended to ACC_W+1 bits).
  - Keep the low ACC_W bits; if bit ACC_W is set, overflow <= 1 (sticky); the sum wraps modulo 2^ACC_W.
  - If count == N_OPS-1: go to DONE and clear count. Else: count <= count+1 and go to IDLE.
- DONE:
  - acc_valid = 1, in_ready = 0.
  - acc_sum and overflow are held stable while acc_ready = 0.
  - On acc_valid && acc_ready at an edge: acc <= 0, overflow <= 0, go to IDLE.

Outputs and timing:
- acc_sum always drives the accumulator register.
- mult_a/mult_b hold the last accepted pair until the next acceptance; they are not cleared after a batch.
- Timing: pair accepted at edge k; its product is accumulated at edge k+1. For the last pair of a batch, acc_valid rises after edge k+1.
- Throughput: at most one pair per 2 cycles. A full batch with no bubbles and acc_ready=1 takes 2*N_OPS+1 cycles until the next batch can be accepted.
- N_OPS = 1: every pair goes IDLE -> EVAL -> DONE.

Boundaries:
- in_valid high outside IDLE: ignored; the pair must be held until in_ready.
- acc_ready high outside DONE: ignored.
- rst_n asserted mid-batch: the partial sum is discarded; the next batch starts from 0 with count = 0.
- Operand values 0 and 15 need no special handling; max product 225.

Test Plan:
1. Batch of pairs (3,5), (15,15), (0,9), (7,2), acc_ready=1 -> acc_sum=254, overflow=0; acc_valid high exactly one cycle, 8 edges after the first acceptance.
2. Four pairs of (15,15) -> acc_sum=900, overflow=0; the next batch of four (1,1) -> acc_sum=4, confirming the accumulator cleared.
3. Backpressure: hold acc_ready=0 for 5 cycles after acc_valid -> acc_valid, acc_sum and overflow stable, in_ready=0 throughout; a pair offered meanwhile is not accepted until after the handshake.
4. ACC_W=8, N_OPS=2, pairs (15,15), (15,15) -> acc_sum=194 (450 mod 256), overflow=1; both clear after the acc handshake.
5. Random in_valid bubbles (0-3 idle cycles) between the pairs of scenario 1 -> same result 254; mult_a/mult_b equal the last accepted operands.
6. Assert rst_n after 2 of 4 pairs -> all outputs 0 immediately (asynchronous); a subsequent full batch (2,3)x4 -> acc_sum=24.
